// File: rtl/mac_pkg.sv
// Shared Q-format constants for the MAC datapath and its narrowing stages.
package mac_pkg;

    localparam int unsigned MAC_IN_BITWIDTH  = 16;
    localparam int unsigned MAC_IN_FRAC      = 12;
    localparam int unsigned MAC_OUT_BITWIDTH = 8;
    localparam int unsigned MAC_OUT_FRAC     = 6;

    localparam int MAC_SAT_MAX = (1 << (MAC_OUT_BITWIDTH - 1)) - 1;
    localparam int MAC_SAT_MIN = -(1 << (MAC_OUT_BITWIDTH - 1));

endpackage

// File: rtl/mac_requant.sv
// Combinational requantizer: round-half-up, arithmetic shift, saturate.
// Optional ReLU clamp when MAC_RELU_EN is defined.
module mac_requant
    import mac_pkg::*;
#(
    parameter int unsigned IN_BITWIDTH  = MAC_IN_BITWIDTH,
    parameter int unsigned IN_FRAC      = MAC_IN_FRAC,
    parameter int unsigned OUT_BITWIDTH = MAC_OUT_BITWIDTH,
    parameter int unsigned OUT_FRAC     = MAC_OUT_FRAC
) (
    input  logic [IN_BITWIDTH-1:0]  i_data,
    output logic [OUT_BITWIDTH-1:0] o_data
);

    localparam int unsigned SHIFT = IN_FRAC - OUT_FRAC;
    localparam logic signed [IN_BITWIDTH:0] RND =
        (IN_BITWIDTH + 1)'(1 << (SHIFT - 1));
    localparam logic signed [IN_BITWIDTH:0] SAT_HI =
        (IN_BITWIDTH + 1)'((1 << (OUT_BITWIDTH - 1)) - 1);
    localparam logic signed [IN_BITWIDTH:0] SAT_LO = ~SAT_HI;

    logic signed [IN_BITWIDTH:0] w_sum;
    logic signed [IN_BITWIDTH:0] w_shr;
    logic [OUT_BITWIDTH-1:0]     w_sat;

    // One extra bit keeps the rounding add from wrapping at the positive limit.
    assign w_sum = $signed({i_data[IN_BITWIDTH-1], i_data}) + RND;
    assign w_shr = w_sum >>> SHIFT;

    always_comb begin
        w_sat = w_shr[OUT_BITWIDTH-1:0];
        if (w_shr > SAT_HI) begin
            w_sat = SAT_HI[OUT_BITWIDTH-1:0];
        end else if (w_shr < SAT_LO) begin
            w_sat = SAT_LO[OUT_BITWIDTH-1:0];
        end
    end

`ifdef MAC_RELU_EN
    assign o_data = w_sat[OUT_BITWIDTH-1] ? '0 : w_sat;
`else
    assign o_data = w_sat;
`endif

endmodule

// File: rtl/mac_requant_fifo.sv
// MAC result capture on DONE rising edge, requantize, buffer, valid/ready out.
// Build option MAC_RELU_EN (in mac_requant) clamps negative results to zero.
module mac_requant_fifo
    import mac_pkg::*;
#(
    parameter int unsigned IN_BITWIDTH  = MAC_IN_BITWIDTH,
    parameter int unsigned IN_FRAC      = MAC_IN_FRAC,
    parameter int unsigned OUT_BITWIDTH = MAC_OUT_BITWIDTH,
    parameter int unsigned OUT_FRAC     = MAC_OUT_FRAC,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CNT_BITWIDTH = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [IN_BITWIDTH-1:0]  i_mout_in,
    input  logic                    i_done_in,
    output logic                    o_stall,
    output logic [OUT_BITWIDTH-1:0] o_q_data,
    output logic                    o_q_valid,
    input  logic                    i_q_ready,
    output logic                    o_overflow,
    output logic [CNT_BITWIDTH-1:0] o_result_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [OUT_BITWIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [AW:0]             r_count;
    logic                    r_done_q;
    logic                    r_overflow;
    logic [CNT_BITWIDTH-1:0] r_result_cnt;

    logic [OUT_BITWIDTH-1:0] w_q_in;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_valid;
    logic                    w_wr;

    mac_requant #(
        .IN_BITWIDTH  (IN_BITWIDTH),
        .IN_FRAC      (IN_FRAC),
        .OUT_BITWIDTH (OUT_BITWIDTH),
        .OUT_FRAC     (OUT_FRAC)
    ) u_requant (
        .i_data (i_mout_in),
        .o_data (w_q_in)
    );

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_push  = i_done_in & ~r_done_q;
    assign w_pop   = w_valid & i_q_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_wr    = w_push & (~w_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_done_q     <= 1'b1;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_result_cnt <= '0;
        end else begin
            r_done_q <= i_done_in;
            if (w_wr) begin
                r_wr_ptr     <= r_wr_ptr + AW'(1);
                r_result_cnt <= r_result_cnt + CNT_BITWIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_wr) begin
                r_overflow <= 1'b1;
            end
            r_count <= r_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && w_wr) begin
            r_mem[r_wr_ptr] <= w_q_in;
        end
    end

    assign o_stall      = w_full;
    assign o_q_valid    = w_valid;
    assign o_q_data     = w_valid ? r_mem[r_rd_ptr] : '0;
    assign o_overflow   = r_overflow;
    assign o_result_cnt = r_result_cnt;

endmodule

// File: tb/tb_mac_requant_fifo.sv
// Bench for mac_requant_fifo: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_mac_requant_fifo;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] mout = '0;
    logic        done = 1'b0;
    logic        ready = 1'b0;
    logic        stall;
    logic [7:0]  q_data;
    logic        q_valid;
    logic        overflow;
    logic [15:0] result_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic       m_prev = 1'b1;
    logic       m_ovf = 1'b0;
    int         m_cnt = 0;

    mac_requant_fifo #(
        .DEPTH (DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_mout_in    (mout),
        .i_done_in    (done),
        .o_stall      (stall),
        .o_q_data     (q_data),
        .o_q_valid    (q_valid),
        .i_q_ready    (ready),
        .o_overflow   (overflow),
        .o_result_cnt (result_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    // Q3.12 -> Q1.6 with round-half-up, computed as floor((v + 32) / 64).
    function automatic logic [7:0] ref_q(input logic [15:0] x);
        int v;
        int t;
        int r;
        v = int'($signed(x));
        t = v + 32;
        r = (t >= 0) ? t / 64 : -((-t + 63) / 64);
        if (r > 127) r = 127;
        if (r < -128) r = -128;
`ifdef MAC_RELU_EN
        if (r < 0) r = 0;
`endif
        return 8'(r);
    endfunction

    // Advance one clock; the model consumes the inputs seen at that edge.
    task automatic step();
        bit pop;
        bit push;
        int size0;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_prev = 1'b1;
            m_ovf  = 1'b0;
            m_cnt  = 0;
        end else begin
            size0 = m_q.size();
            pop   = (size0 > 0) && ready;
            push  = done && !m_prev;
            m_prev = done;
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (size0 < DEPTH || pop) begin
                    m_q.push_back(ref_q(mout));
                    m_cnt++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        done = 1'b0;
        ready = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (q_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_valid: got %b expected 0", q_valid);
        end
        n_checks++;
        if (stall !== 1'b0) begin
            n_errors++; $display("FAIL reset_stall: got %b expected 0", stall);
        end
        n_checks++;
        if (overflow !== 1'b0 || result_cnt !== 16'd0 || q_data !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_state: got ovf=%b cnt=%0d data=%h expected 0/0/00",
                     overflow, result_cnt, q_data);
        end
    endtask

    task automatic test_single();
        mout = 16'h1000;
        done = 1'b1;
        ready = 1'b1;
        step();
        n_checks++;
        if (q_valid !== 1'b1 || q_data !== 8'h40 || result_cnt !== 16'd1) begin
            n_errors++;
            $display("FAIL single_push: got v=%b d=%h cnt=%0d expected 1/40/1",
                     q_valid, q_data, result_cnt);
        end
        done = 1'b0;
        step();
        n_checks++;
        if (q_valid !== 1'b0 || q_data !== 8'h00) begin
            n_errors++;
            $display("FAIL single_pop: got v=%b d=%h expected 0/00", q_valid, q_data);
        end
    endtask

    task automatic test_rounding();
        logic [15:0] vin [7];
        logic [7:0]  vexp [7];
        vin = '{16'h0020, 16'h001F, 16'hFFE0, 16'hFFDF, 16'h7FFF, 16'h8000, 16'h1000};
`ifdef MAC_RELU_EN
        vexp = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h40};
`else
        vexp = '{8'h01, 8'h00, 8'h00, 8'hFF, 8'h7F, 8'h80, 8'h40};
`endif
        for (int i = 0; i < 7; i++) begin
            mout = vin[i];
            done = 1'b1;
            ready = 1'b0;
            step();
            n_checks++;
            if (q_valid !== 1'b1 || q_data !== vexp[i]) begin
                n_errors++;
                $display("FAIL round_%h: got v=%b d=%h expected 1/%h",
                         vin[i], q_valid, q_data, vexp[i]);
            end
            done = 1'b0;
            ready = 1'b1;
            step();
        end
    endtask

    task automatic test_done_held();
        int cnt0;
        cnt0 = int'(result_cnt);
        mout = 16'h0400;
        done = 1'b1;
        ready = 1'b1;
        repeat (3) step();
        done = 1'b0;
        step();
        n_checks++;
        if (int'(result_cnt) !== cnt0 + 1 || q_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL done_held: got cnt=%0d v=%b expected %0d/0",
                     result_cnt, q_valid, cnt0 + 1);
        end
        done = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();
        done = 1'b0;
        step();
        n_checks++;
        if (result_cnt !== 16'd0 || q_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL done_across_reset: got cnt=%0d v=%b expected 0/0",
                     result_cnt, q_valid);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_q [5];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            mout = 16'($urandom);
            exp_q[i] = ref_q(mout);
            done = 1'b1;
            step();
            if (i == 3) begin
                n_checks++;
                if (stall !== 1'b1 || overflow !== 1'b0) begin
                    n_errors++;
                    $display("FAIL full_after_4: got stall=%b ovf=%b expected 1/0",
                             stall, overflow);
                end
            end
            done = 1'b0;
            step();
        end
        n_checks++;
        if (overflow !== 1'b1 || result_cnt !== 16'd4 || stall !== 1'b1) begin
            n_errors++;
            $display("FAIL drop_5th: got ovf=%b cnt=%0d stall=%b expected 1/4/1",
                     overflow, result_cnt, stall);
        end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (q_valid !== 1'b1 || q_data !== exp_q[i]) begin
                n_errors++;
                $display("FAIL drain_%0d: got v=%b d=%h expected 1/%h",
                         i, q_valid, q_data, exp_q[i]);
            end
            step();
        end
        n_checks++;
        if (q_valid !== 1'b0 || stall !== 1'b0 || overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL drained: got v=%b stall=%b ovf=%b expected 0/0/1",
                     q_valid, stall, overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            mout = 16'($urandom);
            exp_q[i] = ref_q(mout);
            done = 1'b1;
            step();
            done = 1'b0;
            step();
        end
        mout = 16'($urandom);
        done = 1'b1;
        ready = 1'b1;
        n_checks++;
        if (q_data !== exp_q[0] || stall !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_head: got d=%h stall=%b expected %h/1", q_data, stall, exp_q[0]);
        end
        step();
        n_checks++;
        if (stall !== 1'b1 || overflow !== 1'b0 || result_cnt !== 16'd5 ||
            q_data !== exp_q[1]) begin
            n_errors++;
            $display("FAIL b2b_pushpop: got stall=%b ovf=%b cnt=%0d d=%h expected 1/0/5/%h",
                     stall, overflow, result_cnt, q_data, exp_q[1]);
        end
        done = 1'b0;
        ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        n_checks++;
        if (q_valid !== 1'b0 || stall !== 1'b0 || q_data !== 8'h00) begin
            n_errors++;
            $display("FAIL mid_reset: got v=%b stall=%b d=%h expected 0/0/00",
                     q_valid, stall, q_data);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic [7:0] exp_d;
        for (int c = 0; c < 600; c++) begin
            mout  = 16'($urandom);
            done  = 1'($urandom_range(0, 1));
            ready = ($urandom_range(0, 2) == 0);
            rst   = ($urandom_range(0, 149) == 0);
            step();
            exp_d = (m_q.size() > 0) ? m_q[0] : 8'h00;
            n_checks++;
            if (q_valid !== (m_q.size() > 0) || q_data !== exp_d ||
                stall !== (m_q.size() == DEPTH) || overflow !== m_ovf ||
                result_cnt !== 16'(m_cnt)) begin
                n_errors++;
                $display("FAIL random_c%0d: got v=%b d=%h st=%b ov=%b cnt=%0d expected %b/%h/%b/%b/%0d",
                         c, q_valid, q_data, stall, overflow, result_cnt,
                         (m_q.size() > 0), exp_d, (m_q.size() == DEPTH), m_ovf, 16'(m_cnt));
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rounding();
        test_done_held();
        test_overflow();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
